pe_result_collector: RTL and testbench

- Downstream drain stage for one row of systolic PE_VCounter_FP cells.
- Each PE raises its finish flag for exactly one cycle per matrix, with its accumulated result valid only in that cycle. The PEs in a row finish skewed by one cycle each.
- The collector captures every result on its finish pulse, never stalling the array, and serialises the results with lane index into a FIFO with valid/ready output.

---
 rtl/pe_array_pkg.sv | 20 ++
 rtl/sync_fifo_fwft.sv | 61 ++++++
 rtl/pe_result_collector.sv | 131 +++++++++++++
 tb/tb_pe_result_collector.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array drain path: default row geometry,
// lane-index width helper and the result word layout.
package pe_array_pkg;

    localparam int DIMENSION_DEF = 4;
    localparam int I_BITS_DEF    = 8;
    localparam int O_BITS_DEF    = 2*I_BITS_DEF + $clog2(DIMENSION_DEF);
    localparam int IDX_BITS_DEF  = (DIMENSION_DEF > 1) ? $clog2(DIMENSION_DEF) : 1;

    // A one-lane row still needs a 1-bit index field.
    function automatic int idx_bits(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    typedef struct packed {
        logic [IDX_BITS_DEF-1:0]      index;
        logic signed [O_BITS_DEF-1:0] data;
    } result_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with async active-low reset and
// synchronous flush; head reads as zero while empty.
module sync_fifo_fwft
    import pe_array_pkg::*;
#(
    parameter int WIDTH = IDX_BITS_DEF + O_BITS_DEF,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] fill
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign fill    = count;
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push needs, so full + pop still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pe_result_collector.sv
// Drain stage for one systolic PE row: captures finish-pulse results into
// per-lane holds, arbitrates lowest lane first into a FWFT FIFO.
// Optional PE_COLLECT_ROWDONE_EN adds o_last marking every DIMENSION-th pop.
module pe_result_collector
    import pe_array_pkg::*;
#(
    parameter int DIMENSION  = DIMENSION_DEF,
    parameter int I_BITS     = I_BITS_DEF,
    parameter int O_BITS     = 2*I_BITS + $clog2(DIMENSION),
    parameter int FIFO_DEPTH = 8,
    localparam int IDX_BITS  = idx_bits(DIMENSION),
    localparam int FILL_BITS = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic [DIMENSION*O_BITS-1:0]   i_c,
    input  logic [DIMENSION-1:0]          i_finish,
    output logic signed [O_BITS-1:0]      o_data,
    output logic [IDX_BITS-1:0]           o_index,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [FILL_BITS-1:0]          o_fill,
    output logic                          o_overflow
`ifdef PE_COLLECT_ROWDONE_EN
    ,
    output logic                          o_last
`endif
);

    logic [DIMENSION-1:0]       hold_v;
    logic signed [O_BITS-1:0]   hold_d [DIMENSION];
    logic                       any_hold;
    logic [IDX_BITS-1:0]        win_idx;
    logic                       pop;
    logic                       push;
    logic                       full;
    logic                       empty;
    logic [DIMENSION-1:0]       xfer;
    logic [DIMENSION-1:0]       capture;
    logic [DIMENSION-1:0]       drop;
    logic [IDX_BITS+O_BITS-1:0] head;

    // Fixed priority: scanning downward leaves the lowest held lane as winner.
    always_comb begin
        any_hold = 1'b0;
        win_idx  = '0;
        for (int j = DIMENSION-1; j >= 0; j--) begin
            if (hold_v[j]) begin
                any_hold = 1'b1;
                win_idx  = IDX_BITS'(j);
            end
        end
    end

    assign pop  = o_valid && i_ready;
    assign push = any_hold && (!full || pop);

    // A lane whose hold leaves this cycle may take a new result at once.
    always_comb begin
        xfer    = '0;
        capture = '0;
        drop    = '0;
        for (int j = 0; j < DIMENSION; j++) begin
            xfer[j]    = push && (win_idx == IDX_BITS'(j));
            capture[j] = i_finish[j] && (!hold_v[j] || xfer[j]);
            drop[j]    = i_finish[j] && hold_v[j] && !xfer[j];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_v     <= '0;
            o_overflow <= 1'b0;
        end else if (i_flush) begin
            hold_v     <= '0;
            o_overflow <= 1'b0;
        end else begin
            for (int j = 0; j < DIMENSION; j++) begin
                if (capture[j])   hold_v[j] <= 1'b1;
                else if (xfer[j]) hold_v[j] <= 1'b0;
            end
            if (|drop) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        for (int j = 0; j < DIMENSION; j++) begin
            if (capture[j]) hold_d[j] <= i_c[j*O_BITS +: O_BITS];
        end
    end

    sync_fifo_fwft #(
        .WIDTH (IDX_BITS + O_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (i_clock),
        .reset_n   (i_reset_n),
        .flush     (i_flush),
        .push      (push),
        .push_data ({win_idx, hold_d[win_idx]}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .fill      (o_fill)
    );

    assign o_valid = !empty;
    assign o_index = head[IDX_BITS+O_BITS-1 -: IDX_BITS];
    assign o_data  = head[O_BITS-1:0];

`ifdef PE_COLLECT_ROWDONE_EN
    localparam logic [IDX_BITS-1:0] LAST_CNT = IDX_BITS'(DIMENSION-1);

    logic [IDX_BITS-1:0] pop_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pop_cnt <= '0;
        end else if (i_flush) begin
            pop_cnt <= '0;
        end else if (pop) begin
            pop_cnt <= (pop_cnt == LAST_CNT) ? '0 : pop_cnt + 1'b1;
        end
    end

    assign o_last = o_valid && (pop_cnt == LAST_CNT);
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// Bench for pe_result_collector: queue-based reference model with a per-cycle
// compare process, plus directed scenarios with literal expectations.
module tb_pe_result_collector;

    localparam int D     = 4;
    localparam int OB    = 18;
    localparam int DEPTH = 8;
    localparam int IW    = 2;
    localparam int FW    = 4;

    logic                    clk    = 1'b0;
    logic                    rst_n  = 1'b1;
    logic                    flush  = 1'b0;
    logic                    ready  = 1'b0;
    logic [D*OB-1:0]         c_bus  = '0;
    logic [D-1:0]            fin    = '0;
    logic signed [OB-1:0]    data;
    logic [IW-1:0]           index;
    logic                    valid;
    logic [FW-1:0]           fill;
    logic                    ovf;
`ifdef PE_COLLECT_ROWDONE_EN
    logic                    last;
`endif

    pe_result_collector #(
        .DIMENSION  (D),
        .I_BITS     (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_flush    (flush),
        .i_c        (c_bus),
        .i_finish   (fin),
        .o_data     (data),
        .o_index    (index),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_fill     (fill),
        .o_overflow (ovf)
`ifdef PE_COLLECT_ROWDONE_EN
        ,
        .o_last     (last)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;
    int vals [12];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: holds as arrays, FIFO as a queue.
    typedef struct packed {
        logic [IW-1:0]        idx;
        logic signed [OB-1:0] d;
    } word_t;

    word_t                q[$];
    bit                   mhv [D];
    logic signed [OB-1:0] mhd [D];
    bit                   movf;
    int                   mpop;

    task automatic model_clear();
        q.delete();
        for (int j = 0; j < D; j++) mhv[j] = 1'b0;
        movf = 1'b0;
        mpop = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || flush) begin
                model_clear();
            end else begin
                bit do_pop;
                bit do_push;
                int win;
                bit hv0 [D];
                do_pop = (q.size() > 0) && ready;
                win = -1;
                for (int j = D-1; j >= 0; j--) if (mhv[j]) win = j;
                do_push = (win >= 0) && ((q.size() < DEPTH) || do_pop);
                hv0 = mhv;
                if (do_pop) begin
                    void'(q.pop_front());
                    mpop = (mpop + 1) % D;
                end
                if (do_push) begin
                    q.push_back(word_t'{idx: IW'(win), d: mhd[win]});
                    mhv[win] = 1'b0;
                end
                for (int j = 0; j < D; j++) begin
                    if (fin[j]) begin
                        if (!hv0[j] || (do_push && win == j)) begin
                            mhv[j] = 1'b1;
                            mhd[j] = c_bus[j*OB +: OB];
                        end else begin
                            movf = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                check("m_valid", valid, q.size() > 0);
                check("m_fill", fill, q.size());
                check("m_ovf", ovf, movf);
                if (q.size() > 0) begin
                    check("m_data", data, q[0].d);
                    check("m_index", index, q[0].idx);
                end
`ifdef PE_COLLECT_ROWDONE_EN
                check("m_last", last, (q.size() > 0) && (mpop == D-1));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int j, input int v);
        c_bus[j*OB +: OB] = OB'(v);
    endtask

    task automatic expect_head(input string n, input int idx, input int v);
        @(negedge clk);
        check({n, "_valid"}, valid, 1);
        check({n, "_index"}, index, idx);
        check({n, "_data"}, data, v);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic skewed_pulses(input int n);
        for (int t = 0; t < n; t++) begin
            vals[t] = int'($urandom_range(0, 120000)) - 60000;
            set_lane(t % D, vals[t]);
            fin = D'(1 << (t % D));
            tick();
        end
        fin = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_fill", fill, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", data, 0);
        check("rst_index", index, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Skewed row with i_ready held high.
        ready = 1'b1;
        tick();
        set_lane(0, 100);   fin = 4'b0001; tick();
        set_lane(1, -5);    fin = 4'b0010;
        @(negedge clk);
        check("s1_pre_valid", valid, 0);
        tick();
        set_lane(2, 32767); fin = 4'b0100;
        expect_head("s1_w0", 0, 100);
        tick();
        set_lane(3, 0);     fin = 4'b1000;
        expect_head("s1_w1", 1, -5);
        tick();
        fin = '0;
        expect_head("s1_w2", 2, 32767);
        tick();
        expect_head("s1_w3", 3, 0);
        tick();
        @(negedge clk);
        check("s1_empty", valid, 0);
        check("s1_ovf", ovf, 0);

        // All lanes finishing together drain in lane order.
        for (int j = 0; j < D; j++) set_lane(j, j + 1);
        fin = 4'b1111;
        tick();
        fin = '0;
        @(negedge clk);
        check("s2_pre_valid", valid, 0);
        for (int k = 0; k < D; k++) begin
            tick();
            expect_head("s2_w", k, k + 1);
        end
        tick();
        @(negedge clk);
        check("s2_empty", valid, 0);

        // Backpressure: three skewed matrices, then one pulse too many.
        do_flush();
        ready = 1'b0;
        skewed_pulses(12);
        tick();
        tick();
        @(negedge clk);
        check("s3_fill", fill, 8);
        check("s3_ovf_clear", ovf, 0);
        check("s3_head_idx", index, 0);
        check("s3_head_data", data, vals[0]);
        set_lane(0, 777);
        fin = 4'b0001;
        tick();
        fin = '0;
        @(negedge clk);
        check("s3_ovf_set", ovf, 1);
        check("s3_stall_data", data, vals[0]);
        check("s3_stall_fill", fill, 8);
        ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            tick();
            expect_head("s3_w", k % D, vals[k]);
            if (k == 1) check("s3_pushpop_fill", fill, 8);
        end
        repeat (12) tick();
        @(negedge clk);
        check("s3_drained", valid, 0);

        // Full FIFO with a pending hold: push and pop together.
        do_flush();
        ready = 1'b0;
        skewed_pulses(9);
        tick();
        tick();
        @(negedge clk);
        check("s4_fill_full", fill, 8);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        @(negedge clk);
        check("s4_fill_kept", fill, 8);
        check("s4_ovf", ovf, 0);
        check("s4_head_idx", index, 1);
        check("s4_head_data", data, vals[1]);
        ready = 1'b1;
        repeat (12) tick();

        // Asynchronous reset mid-drain.
        do_flush();
        ready = 1'b0;
        skewed_pulses(5);
        repeat (3) tick();
        @(negedge clk);
        check("s5_fill", fill, 5);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", valid, 0);
        check("s5_rst_fill", fill, 0);
        check("s5_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Same drain state cleared by flush instead.
        tick();
        skewed_pulses(5);
        repeat (3) tick();
        @(negedge clk);
        check("s5f_fill_pre", fill, 5);
        do_flush();
        @(negedge clk);
        check("s5f_valid", valid, 0);
        check("s5f_fill", fill, 0);
        check("s5f_ovf", ovf, 0);

`ifdef PE_COLLECT_ROWDONE_EN
        // Two skewed matrices drained: o_last on pops 4 and 8 only.
        begin
            int popn;
            popn = 0;
            ready = 1'b1;
            for (int t = 0; t < 16; t++) begin
                if (t < 8) begin
                    set_lane(t % D, t + 10);
                    fin = D'(1 << (t % D));
                end else begin
                    fin = '0;
                end
                tick();
                @(negedge clk);
                if (valid) begin
                    popn++;
                    check("s6_last", last, (popn % D) == 0);
                end
            end
            check("s6_popcount", popn, 8);
        end
`endif

        // Randomised traffic with occasional backpressure bursts and flushes.
        for (int i = 0; i < 1500; i++) begin
            ready = ((i % 200) < 140) ? ($urandom_range(0, 3) != 0) : 1'b0;
            flush = ($urandom_range(0, 99) == 0);
            fin   = D'($urandom & $urandom);
            for (int j = 0; j < D; j++) set_lane(j, int'($urandom));
            tick();
        end
        flush = 1'b0;
        fin   = '0;
        ready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("end_empty", valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
